// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage ARM pipeline.
// Define HAZARD_PERF_EN to build the saturating stall/flush/forward performance counters.
module hazard_unit #(
  parameter int unsigned WDOG_MAX = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPending,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             perf_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       state_o,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  localparam int unsigned     WDOG_W    = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);
  localparam logic [3:0]      PC_REG    = 4'd15;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    PCDRAIN = 2'b10
  } state_t;

  state_t            state;
  logic [WDOG_W-1:0] wdog;
  logic              ldrStall;

  // Memory stage wins over writeback; the PC is never a forwarding source.
  function automatic logic [1:0] fwdSel(input logic [3:0] ra, input logic [3:0] waM,
                                        input logic [3:0] waW, input logic rwM,
                                        input logic rwW);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_REG) begin
      if (rwM && (ra == waM))      sel = 2'b10;
      else if (rwW && (ra == waW)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Zero-latency pipeline controls; reset holds D/E flushed and nothing stalled.
  always_comb begin
    ldrStall  = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (reset) begin
      ForwardAE = fwdSel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
      ForwardBE = fwdSel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
      StallD    = ldrStall;
      StallF    = ldrStall | PCWrPending;
      FlushD    = PCWrPending | PCSrcW | BranchTakenE;
      FlushE    = ldrStall | BranchTakenE;
    end
  end

  // Load-use / PC-drain tracker with drain watchdog and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      wdog       <= '0;
      hazard_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (BranchTakenE) begin
            state <= RUN;
          end else if (PCWrPending) begin
            state <= PCDRAIN;
            wdog  <= '0;
          end else if (ldrStall) begin
            state <= LDSTALL;
          end
        end
        LDSTALL: begin
          state <= RUN;
          if (ldrStall) hazard_err <= 1'b1;
        end
        PCDRAIN: begin
          if (PCSrcW) begin
            state <= RUN;
          end else if (wdog == WDOG_LAST) begin
            hazard_err <= 1'b1;
            state      <= RUN;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign state_o = state;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic fwdEvent;
  assign fwdEvent = (ForwardAE != 2'b00) | (ForwardBE != 2'b00);

  // Saturating event counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (!reset || perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (StallD && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushE && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (fwdEvent && (fwd_cnt != CNT_MAX)) fwd_cnt   <= fwd_cnt + CNT_W'(1);
    end
  end
`else
  logic unusedPerfClr;
  assign unusedPerfClr = perf_clr;
  assign stall_cnt     = '0;
  assign flush_cnt     = '0;
  assign fwd_cnt       = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit forwarding, stalls, FSM, watchdog and counters.
// Counter expectations follow HAZARD_PERF_EN as seen by this compile.
module tb_hazard_unit;

  localparam int unsigned CNT_W = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [1:0] RUN = 2'b00, LDS = 2'b01, DRN = 2'b10;

  typedef struct packed {
    logic       rstN;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwM, rwW, memE, pcPend, pcSrcW, brE, clr;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
    logic [1:0] st;
    logic       err;
  } obs_t;

  typedef struct packed {
    logic [CNT_W-1:0] sc, fc, wc;
  } cnt_t;

  logic clk, reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCWrPending, PCSrcW, BranchTakenE, perf_clr;
  logic [1:0] ForwardAE, ForwardBE, state_o;
  logic StallF, StallD, FlushD, FlushE, hazard_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, fwd_cnt;

  int errors = 0;
  int checks = 0;
  obs_t expQ[$];
  cnt_t cntQ[$];
  stim_t IDLE;

  hazard_unit #(.WDOG_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPending(PCWrPending), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .perf_clr(perf_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .state_o(state_o), .hazard_err(hazard_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic apply(input stim_t s);
    reset = s.rstN; RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w; RegWriteM = s.rwM; RegWriteW = s.rwW;
    MemtoRegE = s.memE; PCWrPending = s.pcPend; PCSrcW = s.pcSrcW;
    BranchTakenE = s.brE; perf_clr = s.clr;
  endtask

  task automatic hold(input stim_t s, input int n);
    repeat (n) begin
      @(negedge clk);
      apply(s);
    end
  endtask

  task automatic doReset();
    stim_t s;
    s = IDLE; s.rstN = 1'b0;
    hold(s, 2);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.fa = ForwardAE; o.fb = ForwardBE; o.sf = StallF; o.sd = StallD;
    o.fd = FlushD; o.fe = FlushE; o.st = state_o; o.err = hazard_err;
    return o;
  endfunction

  function automatic obs_t mkExp(input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                                 input logic sd, input logic fd, input logic fe,
                                 input logic [1:0] st, input logic err);
    obs_t o;
    o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.fd = fd; o.fe = fe; o.st = st; o.err = err;
    return o;
  endfunction

  function automatic stim_t ldr(input stim_t b);
    stim_t s;
    s = b; s.memE = 1'b1; s.wa3e = 4'd2; s.ra2d = 4'd2;
    return s;
  endfunction

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; stim_t s, busy; obs_t got, want; cnt_t cg, cw;
    busy = ldr(IDLE); busy.pcPend = 1'b1; busy.rwM = 1'b1; busy.wa3m = 4'd3; busy.ra1e = 4'd3;
    s = busy; s.rstN = 1'b0;
    hold(s, 1);
    st.push_back(s);    ex.push_back(mkExp(0, 0, 0, 0, 1, 1, RUN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    st.push_back(busy); ex.push_back(mkExp(2, 0, 1, 1, 1, 1, RUN, 0));
    s = IDLE; s.pcPend = 1'b1;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, DRN, 0));
    s = busy; s.rstN = 1'b0;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 0, 0, 1, 1, DRN, 0));
    s = IDLE; s.rstN = 1'b0;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 0, 0, 1, 1, RUN, 0));
    s = IDLE; s.memE = 1'b1; s.wa3e = 4'd2; s.ra1d = 4'd2;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 1, 1, 0, 1, RUN, 0));
    s.rstN = 1'b0;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 0, 0, 1, 1, LDS, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); expQ.push_back(ex[i]); #1;
      want = expQ.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, got, want);
      end
    end
    cntQ.push_back('0);
    cw = cntQ.pop_front(); cg = {stall_cnt, flush_cnt, fwd_cnt}; checks++;
    if (cg !== cw) begin
      errors++;
      $display("FAIL reset_counters got=%h exp=%h", cg, cw);
    end
  endtask

  task automatic test_forwarding();
    stim_t st[$]; obs_t ex[$]; stim_t s; obs_t got, want;
    doReset();
    s = IDLE; s.rwM = 1'b1; s.wa3m = 4'd3; s.rwW = 1'b1; s.wa3w = 4'd3; s.ra1e = 4'd3;
    st.push_back(s); ex.push_back(mkExp(2, 0, 0, 0, 0, 0, RUN, 0));
    s.wa3m = 4'd5;
    st.push_back(s); ex.push_back(mkExp(1, 0, 0, 0, 0, 0, RUN, 0));
    s.ra1e = 4'd15; s.wa3m = 4'd15; s.wa3w = 4'd15;
    st.push_back(s); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    s = IDLE; s.ra2e = 4'd7; s.wa3w = 4'd7; s.rwW = 1'b1; s.wa3m = 4'd7;
    st.push_back(s); ex.push_back(mkExp(0, 1, 0, 0, 0, 0, RUN, 0));
    s.rwM = 1'b1; s.ra1e = 4'd7;
    st.push_back(s); ex.push_back(mkExp(2, 2, 0, 0, 0, 0, RUN, 0));
    s = IDLE; s.ra1e = 4'd9; s.wa3w = 4'd9; s.ra2e = 4'd4; s.wa3m = 4'd4;
    st.push_back(s); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); expQ.push_back(ex[i]); #1;
      want = expQ.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL forwarding[%0d] got=%b exp=%b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; obs_t ex[$]; stim_t s; obs_t got, want;
    doReset();
    st.push_back(ldr(IDLE)); ex.push_back(mkExp(0, 0, 1, 1, 0, 1, RUN, 0));
    st.push_back(IDLE);      ex.push_back(mkExp(0, 0, 0, 0, 0, 0, LDS, 0));
    st.push_back(IDLE);      ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    s = IDLE; s.memE = 1'b1; s.wa3e = 4'd6; s.ra1d = 4'd6;
    st.push_back(s);         ex.push_back(mkExp(0, 0, 1, 1, 0, 1, RUN, 0));
    st.push_back(s);         ex.push_back(mkExp(0, 0, 1, 1, 0, 1, LDS, 0));
    st.push_back(IDLE);      ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 1));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); expQ.push_back(ex[i]); #1;
      want = expQ.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, got, want);
      end
    end
  endtask

  task automatic test_pc_drain();
    stim_t st[$]; obs_t ex[$]; stim_t p, w, b; obs_t got, want;
    doReset();
    p = IDLE; p.pcPend = 1'b1;
    w = IDLE; w.pcSrcW = 1'b1;
    b = p;    b.pcSrcW = 1'b1;
    st.push_back(p);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, RUN, 0));
    st.push_back(p);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, DRN, 0));
    st.push_back(p);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, DRN, 0));
    st.push_back(w);    ex.push_back(mkExp(0, 0, 0, 0, 1, 0, DRN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    st.push_back(b);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, RUN, 0));
    st.push_back(w);    ex.push_back(mkExp(0, 0, 0, 0, 1, 0, DRN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    st.push_back(p);    ex.push_back(mkExp(0, 0, 1, 0, 1, 0, RUN, 0));
    for (int k = 0; k < 4; k++) begin
      st.push_back(p);  ex.push_back(mkExp(0, 0, 1, 0, 1, 0, DRN, 0));
    end
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 1));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); expQ.push_back(ex[i]); #1;
      want = expQ.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pc_drain[%0d] got=%b exp=%b", i, got, want);
      end
    end
  endtask

  task automatic test_branch_ldr();
    stim_t st[$]; obs_t ex[$]; stim_t s; obs_t got, want;
    doReset();
    s = ldr(IDLE); s.brE = 1'b1;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 1, 1, 1, 1, RUN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    s = IDLE; s.brE = 1'b1; s.pcPend = 1'b1;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 1, 0, 1, 1, RUN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    s = ldr(IDLE); s.pcPend = 1'b1;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 1, 1, 1, 1, RUN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, DRN, 0));
    s = IDLE; s.pcSrcW = 1'b1;
    st.push_back(s);    ex.push_back(mkExp(0, 0, 0, 0, 1, 0, DRN, 0));
    st.push_back(IDLE); ex.push_back(mkExp(0, 0, 0, 0, 0, 0, RUN, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); expQ.push_back(ex[i]); #1;
      want = expQ.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch_ldr[%0d] got=%b exp=%b", i, got, want);
      end
    end
  endtask

  task automatic test_perf();
    stim_t s; cnt_t cg, cw;
    doReset();
    s = ldr(IDLE); s.rwM = 1'b1; s.wa3m = 4'd3; s.ra1e = 4'd3;
    hold(s, 5);
    @(negedge clk); apply(IDLE);
    cntQ.push_back({CNT_W'(PERF ? 5 : 0), CNT_W'(PERF ? 5 : 0), CNT_W'(PERF ? 5 : 0)}); #1;
    cw = cntQ.pop_front(); cg = {stall_cnt, flush_cnt, fwd_cnt}; checks++;
    if (cg !== cw) begin
      errors++;
      $display("FAIL perf_count got=%h exp=%h", cg, cw);
    end
    hold(ldr(IDLE), 20);
    @(negedge clk); apply(IDLE);
    cntQ.push_back({CNT_W'(PERF ? 15 : 0), CNT_W'(PERF ? 15 : 0), CNT_W'(PERF ? 5 : 0)}); #1;
    cw = cntQ.pop_front(); cg = {stall_cnt, flush_cnt, fwd_cnt}; checks++;
    if (cg !== cw) begin
      errors++;
      $display("FAIL perf_saturate got=%h exp=%h", cg, cw);
    end
    s = ldr(IDLE); s.clr = 1'b1;
    hold(s, 1);
    @(negedge clk); apply(IDLE);
    cntQ.push_back('0); #1;
    cw = cntQ.pop_front(); cg = {stall_cnt, flush_cnt, fwd_cnt}; checks++;
    if (cg !== cw) begin
      errors++;
      $display("FAIL perf_clear got=%h exp=%h", cg, cw);
    end
    checks++;
    if (hazard_err !== 1'b1) begin
      errors++;
      $display("FAIL perf_clr_keeps_err got=%b exp=1", hazard_err);
    end
  endtask

  initial begin
    IDLE = '0;
    IDLE.rstN = 1'b1;
    apply(IDLE);
    reset = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_pc_drain();
    test_branch_ldr();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the 5-stage ARM core: the consumer of the control unit's hazard-related outputs (RegWriteM/W, MemtoRegE, PCWrPending, PCSrcW, BranchTakenE). It returns the stall, flush and forwarding controls that the control unit and datapath use, including FlushE. A small FSM tracks load-use stalls and PC-write drains, runs a drain watchdog, and optionally keeps saturating performance counters.

## Interface
- Parameters:
- WDOG_MAX, 4: maximum cycles allowed in PCDRAIN before hazard_err sets.
- CNT_W, 16: performance counter width.
- Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- RA1D, RA2D  in  4  source registers in Decode.
- RA1E, RA2E  in  4  source registers in Execute.
- WA3E, WA3M, WA3W  in  4  destination registers in E/M/W.
- RegWriteM, RegWriteW  in  1  register writes pending in M/W.
- MemtoRegE  in  1  load in Execute.
- PCWrPending  in  1  PC write in flight (D, E or M).
- PCSrcW  in  1  PC write retiring in Writeback.
- BranchTakenE  in  1  branch resolved taken in Execute.
- perf_clr  in  1  synchronous counter clear.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls.
- state_o  out  2  FSM state: RUN = 00, LDSTALL = 01, PCDRAIN = 10.
- hazard_err  out  1  sticky protocol error.
- stall_cnt, flush_cnt, fwd_cnt  out  CNT_W  performance counters.

## Operation
- Forwarding (combinational), shown for ForwardAE; ForwardBE is the same using RA2E:
  - 10 if RegWriteM and RA1E == WA3M.
  - otherwise 01 if RegWriteW and RA1E == WA3W.
  - otherwise 00.
  - M has priority over W. A match on R15 never forwards (result 00).
- Load-use stall: LDRstall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)).
- StallD = LDRstall.
- StallF = LDRstall | PCWrPending.
- FlushD = PCWrPending | PCSrcW | BranchTakenE.
- FlushE = LDRstall | BranchTakenE.
- FSM transitions, in RUN (first matching rule wins):
  - BranchTakenE: stay in RUN.
  - PCWrPending: go to PCDRAIN and clear wdog.
  - LDRstall: go to LDSTALL.
- FSM transitions, in LDSTALL:
  - Always return to RUN next cycle.
  - If LDRstall is still 1 in LDSTALL, set hazard_err. Execute was flushed, so a repeat stall is illegal.
- FSM transitions, in PCDRAIN:
  - PCSrcW: go to RUN.
  - Otherwise increment wdog.
  - When wdog reaches WDOG_MAX-1 with no PCSrcW: set hazard_err and go to RUN.
- hazard_err stays set until reset. perf_clr does not clear it.

## Timing
- Forward, stall and flush outputs are combinational from the current-cycle inputs, with zero latency.
- state_o, wdog, hazard_err and the counters update on the rising clk edge.
- Reset low, sampled at an edge:
  - state_o = 00, wdog = 0, hazard_err = 0, all counters = 0.
  - While reset is low, combinational outputs are forced to: FlushD = 1, FlushE = 1, StallF = StallD = 0, ForwardAE = ForwardBE = 00.
- Reset asserted mid-PCDRAIN or mid-LDSTALL: return to RUN on the next edge with no error recorded.
- Simultaneous LDRstall and BranchTakenE:
  - FlushE = 1, StallD = 1, FlushD = 1.
  - FSM stays in RUN.
- Simultaneous PCWrPending and LDRstall in RUN: PCDRAIN wins. StallF and StallD are both 1.
- PCSrcW in the same cycle as entering PCDRAIN is ignored by the FSM. Drain exit is evaluated only while already in PCDRAIN.

## Configuration
- Macro HAZARD_PERF_EN.
- When defined, each counter increments by 1 per cycle when its event occurs and saturates at all-ones:
  - stall_cnt: StallD = 1.
  - flush_cnt: FlushE = 1.
  - fwd_cnt: ForwardAE != 00 or ForwardBE != 00.
- perf_clr = 1 zeroes all counters at the edge and takes priority over increment.
- When undefined: no counter flops are built, the counters read constant 0, and perf_clr is ignored.

## Test plan
- Forwarding priority: RegWriteM = 1, WA3M = 3; RegWriteW = 1, WA3W = 3; RA1E = 3 -> ForwardAE = 10. Change WA3M to 5 -> ForwardAE = 01. Set RA1E = WA3M = 15 -> ForwardAE = 00.
- Load-use: MemtoRegE = 1, WA3E = 2, RA2D = 2 -> StallF = StallD = FlushE = 1. Next edge state_o = 01, following edge 00. Holding LDRstall high for 2 cycles -> hazard_err = 1.
- PC drain: pulse PCWrPending for 3 cycles, then PCSrcW = 1 -> state goes 00 -> 10 -> ... -> 00, FlushD = 1 throughout, hazard_err = 0. Withholding PCSrcW for 4 cycles -> hazard_err = 1 and state returns to 00.
- Branch taken with concurrent load-use -> FlushD = FlushE = 1, state_o stays 00.
- HAZARD_PERF_EN: 5 stall cycles -> stall_cnt = 5. Preload the counter near all-ones and hold the event -> counter stays at all-ones. perf_clr = 1 -> 0. Without the macro, stall_cnt = 0 under the same stimulus.
- Reset (low) asserted in PCDRAIN -> state_o = 00, hazard_err = 0, counters = 0, FlushD = FlushE = 1 while reset is low.
